// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - maze grid geometry, checkpoint cells and editor FSM states
// Shared with the maze renderer so both sides agree on cell layout and checkpoints.
package maze_pkg;

   localparam int COLS  = 18;
   localparam int ROWS  = 11;
   localparam int CELLS = COLS * ROWS;
   localparam int IDX_W = 8;

   localparam logic [IDX_W-1:0] CKPT_0 = 8'd31;
   localparam logic [IDX_W-1:0] CKPT_1 = 8'd37;
   localparam logic [IDX_W-1:0] CKPT_2 = 8'd113;
   localparam logic [IDX_W-1:0] CKPT_3 = 8'd139;
   localparam logic [IDX_W-1:0] CKPT_4 = 8'd178;

   localparam logic [CELLS-1:0] CKPT_MASK = (CELLS'(1) << CKPT_0) | (CELLS'(1) << CKPT_1) |
                                            (CELLS'(1) << CKPT_2) | (CELLS'(1) << CKPT_3) |
                                            (CELLS'(1) << CKPT_4);

   typedef enum logic {
      EDIT  = 1'b0,
      SWEEP = 1'b1
   } maze_state_e;

   // 18*row as shifts keeps the index path adder-only; 197 fits in 8 bits.
   function automatic logic [IDX_W-1:0] idx_of(input logic [4:0] col, input logic [3:0] row);
      logic [IDX_W-1:0] r8;
      r8 = {4'b0000, row};
      return {3'b000, col} + (r8 << 4) + (r8 << 1);
   endfunction

endpackage

// File: rtl/btn_rise_det.sv
// rtl/btn_rise_det.sv - one-cycle rising-edge pulse from a debounced level
module btn_rise_det (
   input  logic clk_i,
   input  logic resetn_i,
   input  logic level_i,
   output logic rise_o
);

   logic level_q;

   always_ff @(posedge clk_i) begin
      if (!resetn_i) level_q <= 1'b0;
      else           level_q <= level_i;
   end

   assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/maze_cell_writer.sv
// rtl/maze_cell_writer.sv - cursor/edit/sweep producer for the 18x11 maze bitmap
// Optional CHECKPOINT_LOCK_EN: checkpoint cells are forced to 1 on reset, edit and sweep.
module maze_cell_writer
   import maze_pkg::*;
#(
   parameter int                   COLS_P    = COLS,
   parameter int                   ROWS_P    = ROWS,
   parameter logic [CELLS-1:0]     INIT_MAZE = '0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              btn_u,
   input  logic              btn_d,
   input  logic              btn_l,
   input  logic              btn_r,
   input  logic              btn_c,
   input  logic              paint_en,
   input  logic              clear_req,
   output logic [CELLS-1:0]  mazestate,
   output logic [IDX_W-1:0]  cursor_idx,
   output logic              busy,
   output logic              dirty
);

   localparam logic [4:0]       COL_MAX  = 5'(COLS_P - 1);
   localparam logic [3:0]       ROW_MAX  = 4'(ROWS_P - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

`ifdef CHECKPOINT_LOCK_EN
   localparam logic [CELLS-1:0] RESET_MAZE = CKPT_MASK;
   localparam logic [CELLS-1:0] SWEEP_MAZE = INIT_MAZE | CKPT_MASK;
`else
   localparam logic [CELLS-1:0] RESET_MAZE = '0;
   localparam logic [CELLS-1:0] SWEEP_MAZE = INIT_MAZE;
`endif

   logic u_rise, d_rise, l_rise, r_rise, c_rise, clr_rise;

   btn_rise_det u_det_u   (.clk_i(CLK), .resetn_i(RESET), .level_i(btn_u),     .rise_o(u_rise));
   btn_rise_det u_det_d   (.clk_i(CLK), .resetn_i(RESET), .level_i(btn_d),     .rise_o(d_rise));
   btn_rise_det u_det_l   (.clk_i(CLK), .resetn_i(RESET), .level_i(btn_l),     .rise_o(l_rise));
   btn_rise_det u_det_r   (.clk_i(CLK), .resetn_i(RESET), .level_i(btn_r),     .rise_o(r_rise));
   btn_rise_det u_det_c   (.clk_i(CLK), .resetn_i(RESET), .level_i(btn_c),     .rise_o(c_rise));
   btn_rise_det u_det_clr (.clk_i(CLK), .resetn_i(RESET), .level_i(clear_req), .rise_o(clr_rise));

   maze_state_e      state_q, state_d;
   logic [4:0]       col_q, col_d, new_col;
   logic [3:0]       row_q, row_d, new_row;
   logic [IDX_W-1:0] sweep_q, sweep_d;
   logic [CELLS-1:0] maze_q, maze_d;
   logic             dirty_q, dirty_d;
   logic             move;

   assign cursor_idx = idx_of(col_q, row_q);
   assign mazestate  = maze_q;
   assign busy       = (state_q == SWEEP);
   assign dirty      = dirty_q;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      sweep_d = sweep_q;
      maze_d  = maze_q;
      dirty_d = dirty_q;
      new_col = col_q;
      new_row = row_q;
      move    = 1'b0;
      case (state_q)
         EDIT: begin
            if (clr_rise) begin
               state_d = SWEEP;
               sweep_d = '0;
            end else if (c_rise) begin
`ifdef CHECKPOINT_LOCK_EN
               maze_d[cursor_idx] = CKPT_MASK[cursor_idx] | ~maze_q[cursor_idx];
`else
               maze_d[cursor_idx] = ~maze_q[cursor_idx];
`endif
               dirty_d = 1'b1;
            end else if (u_rise) begin
               move    = 1'b1;
               new_row = (row_q == 4'd0) ? ROW_MAX : row_q - 4'd1;
            end else if (d_rise) begin
               move    = 1'b1;
               new_row = (row_q == ROW_MAX) ? 4'd0 : row_q + 4'd1;
            end else if (l_rise) begin
               move    = 1'b1;
               new_col = (col_q == 5'd0) ? COL_MAX : col_q - 5'd1;
            end else if (r_rise) begin
               move    = 1'b1;
               new_col = (col_q == COL_MAX) ? 5'd0 : col_q + 5'd1;
            end
            if (move) begin
               col_d = new_col;
               row_d = new_row;
               if (paint_en) begin
                  maze_d[idx_of(new_col, new_row)] = 1'b1;
                  dirty_d = 1'b1;
               end
            end
         end
         SWEEP: begin
            maze_d[sweep_q] = SWEEP_MAZE[sweep_q];
            sweep_d         = sweep_q + 8'd1;
            if (sweep_q == LAST_IDX) begin
               state_d = EDIT;
               sweep_d = '0;
               col_d   = '0;
               row_d   = '0;
               dirty_d = 1'b0;
            end
         end
         default: state_d = EDIT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= EDIT;
         col_q   <= '0;
         row_q   <= '0;
         sweep_q <= '0;
         maze_q  <= RESET_MAZE;
         dirty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         sweep_q <= sweep_d;
         maze_q  <= maze_d;
         dirty_q <= dirty_d;
      end
   end

endmodule

// File: tb/tb_maze_cell_writer.sv
// tb/tb_maze_cell_writer.sv - directed vector bench for maze_cell_writer
module tb_maze_cell_writer;

   localparam logic [197:0] INIT_P = {99{2'b01}};

   logic         CLK = 1'b0;
   logic         RESET = 1'b0;
   logic         btn_u = 0, btn_d = 0, btn_l = 0, btn_r = 0, btn_c = 0;
   logic         paint_en = 0, clear_req = 0;
   logic [197:0] mazestate;
   logic [7:0]   cursor_idx;
   logic         busy, dirty;

   maze_cell_writer #(.INIT_MAZE(INIT_P)) dut (
      .CLK(CLK), .RESET(RESET),
      .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c),
      .paint_en(paint_en), .clear_req(clear_req),
      .mazestate(mazestate), .cursor_idx(cursor_idx), .busy(busy), .dirty(dirty)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic u, d, l, r, c, p;
      int   exp_idx;
      logic exp_dirty;
      int   bit_idx;
      logic exp_bit;
   } vec_t;

   vec_t         tbl[15];
   int           n_vec = 0;
   int           n_err = 0;
   logic [197:0] rv;
   logic [197:0] exp_sweep;
   logic         lock;
   int           busy_cnt;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [197:0] act, input logic [197:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input int b);
      btn_u = (b == 0); btn_d = (b == 1); btn_l = (b == 2); btn_r = (b == 3); btn_c = (b == 4);
      tick();
      btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0; btn_c = 0;
      tick();
   endtask

   initial begin
`ifdef CHECKPOINT_LOCK_EN
      lock = 1'b1;
`else
      lock = 1'b0;
`endif
      rv = '0;
      if (lock) begin
         rv[31] = 1; rv[37] = 1; rv[113] = 1; rv[139] = 1; rv[178] = 1;
      end
      exp_sweep = INIT_P | rv;

      //          u  d  l  r  c  p   idx dirty bit  val
      tbl[0]  = '{0, 0, 1, 0, 0, 0,  17, 0,  17,  0};
      tbl[1]  = '{1, 0, 0, 0, 0, 0, 197, 0, 197,  0};
      tbl[2]  = '{0, 0, 0, 1, 0, 0, 180, 0, 180,  0};
      tbl[3]  = '{0, 1, 0, 0, 0, 0,   0, 0,   0,  0};
      tbl[4]  = '{0, 0, 0, 1, 0, 0,   1, 0,   1,  0};
      tbl[5]  = '{0, 1, 0, 0, 0, 0,  19, 0,  19,  0};
      tbl[6]  = '{0, 0, 0, 0, 1, 0,  19, 1,  19,  1};
      tbl[7]  = '{1, 0, 0, 0, 1, 0,  19, 1,  19,  0};
      tbl[8]  = '{1, 1, 0, 0, 0, 0,   1, 1,  19,  0};
      tbl[9]  = '{0, 0, 1, 1, 0, 0,   0, 1,   0,  0};
      tbl[10] = '{0, 0, 0, 1, 0, 1,   1, 1,   1,  1};
      tbl[11] = '{0, 0, 0, 1, 0, 1,   2, 1,   2,  1};
      tbl[12] = '{0, 0, 0, 1, 0, 1,   3, 1,   3,  1};
      tbl[13] = '{0, 0, 0, 0, 0, 0,   3, 1,   0,  0};
      tbl[14] = '{1, 0, 0, 0, 0, 1, 183, 1, 183,  1};

      RESET = 0;
      tick();
      RESET = 1;
      chk("reset_maze",  mazestate, rv);
      chk("reset_idx",   198'(cursor_idx), 198'd0);
      chk("reset_busy",  198'(busy), 198'd0);
      chk("reset_dirty", 198'(dirty), 198'd0);

      foreach (tbl[i]) begin
         btn_u = tbl[i].u; btn_d = tbl[i].d; btn_l = tbl[i].l; btn_r = tbl[i].r;
         btn_c = tbl[i].c; paint_en = tbl[i].p;
         tick();
         chk($sformatf("vec%0d_idx", i),   198'(cursor_idx), 198'(tbl[i].exp_idx));
         chk($sformatf("vec%0d_dirty", i), 198'(dirty), 198'(tbl[i].exp_dirty));
         chk($sformatf("vec%0d_bit", i),   198'(mazestate[tbl[i].bit_idx]), 198'(tbl[i].exp_bit));
         btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0; btn_c = 0; paint_en = 0;
         tick();
      end

      // reset mid-edit
      RESET = 0;
      tick();
      RESET = 1;
      chk("rst2_maze",  mazestate, rv);
      chk("rst2_idx",   198'(cursor_idx), 198'd0);
      chk("rst2_busy",  198'(busy), 198'd0);
      chk("rst2_dirty", 198'(dirty), 198'd0);

      // held centre button toggles once
      press(3);
      press(1);
      chk("held_idx", 198'(cursor_idx), 198'd19);
      btn_c = 1;
      repeat (10) tick();
      chk("held_bit", 198'(mazestate[19]), 198'd1);
      btn_c = 0;
      tick();
      press(4);
      chk("second_bit", 198'(mazestate[19]), 198'd0);
      chk("second_dirty", 198'(dirty), 198'd1);

      // clear sweep with a simultaneous move and noise during the sweep
      clear_req = 1; btn_r = 1;
      tick();
      chk("sweep_nomove", 198'(cursor_idx), 198'd19);
      chk("sweep_busy0", 198'(busy), 198'd1);
      busy_cnt = busy ? 1 : 0;
      for (int k = 0; k < 400 && busy; k++) begin
         btn_r     = (k < 150) && (k % 4 == 1);
         btn_c     = (k < 150) && (k % 6 == 2);
         btn_u     = (k < 150) && (k % 8 == 3);
         clear_req = (k < 150) && (k % 10 == 5);
         tick();
         if (busy) busy_cnt++;
      end
      btn_r = 0; btn_c = 0; btn_u = 0; clear_req = 0;
      chk("sweep_len",   198'(busy_cnt), 198'd198);
      chk("sweep_busy",  198'(busy), 198'd0);
      chk("sweep_maze",  mazestate, exp_sweep);
      chk("sweep_idx",   198'(cursor_idx), 198'd0);
      chk("sweep_dirty", 198'(dirty), 198'd0);

      // reset at sweep cycle 100
      press(3);
      clear_req = 1;
      tick();
      clear_req = 0;
      chk("sw2_busy", 198'(busy), 198'd1);
      repeat (99) tick();
      chk("sw2_busy_mid", 198'(busy), 198'd1);
      RESET = 0;
      tick();
      RESET = 1;
      chk("sw2_rst_maze", mazestate, rv);
      chk("sw2_rst_busy", 198'(busy), 198'd0);
      chk("sw2_rst_idx",  198'(cursor_idx), 198'd0);
      tick();
      chk("sw2_edit_busy", 198'(busy), 198'd0);
      chk("sw2_edit_maze", mazestate, rv);

      // checkpoint cell 31 edit
      repeat (5) press(2);
      press(1);
      chk("ck_idx", 198'(cursor_idx), 198'd31);
      press(4);
      chk("ck_first", 198'(mazestate[31]), 198'd1);
      press(4);
      chk("ck_second", 198'(mazestate[31]), 198'(lock));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
